prio_irq_encoder: RTL and testbench

Parametrised, registered successor to the 8:3 combinational priority encoder. Captures N request lines into a pending register, applies an enable mask, and presents the highest-priority pending index on a valid/ready output port. Acceptance clears that pending bit. Sits between raw event/interrupt sources and a single consumer (sequencer or CPU-side handler) that services one index at a time.

---
 rtl/prio_enc_pkg.sv | 11 +
 rtl/prio_pick.sv | 25 ++
 rtl/prio_irq_encoder.sv | 94 +++++++++
 tb/tb_prio_irq_encoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants for the registered priority interrupt encoder.
// Direction and capture-mode encodings are also used by the bench.
package prio_enc_pkg;

    localparam bit PRIO_LOW_FIRST  = 1'b0;
    localparam bit PRIO_HIGH_FIRST = 1'b1;

    localparam bit CAP_LEVEL = 1'b0;
    localparam bit CAP_EDGE  = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational N-to-W priority picker with a found flag.
// Priority direction is selected by HIGH_FIRST.
module prio_pick #(
    parameter int N          = 8,
    parameter bit HIGH_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Ascending scan: the last hit is the highest set bit, the first hit the lowest.
        for (int i = 0; i < N; i++) begin
            if (vec[i] && (HIGH_FIRST || !found)) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_irq_encoder.sv
// Registered priority encoder: latches requests into a pending register and
// presents the highest-priority enabled pending index on a valid/ready port.
//
// state   | meaning
// IDLE    | nothing presented, out_valid=0, out_idx holds last value
// PRESENT | out_idx is valid and held stable until accepted
module prio_irq_encoder
    import prio_enc_pkg::*;
#(
    parameter int N          = 8,
    parameter bit HIGH_FIRST = PRIO_HIGH_FIRST,
    parameter bit EDGE       = CAP_LEVEL,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] mask_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] pending_o
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t         state;
    logic [N-1:0]   pending;
    logic [N-1:0]   req_prev;
    logic [N-1:0]   capture;
    logic [N-1:0]   clear;
    logic [N-1:0]   cand_vec;
    logic           accept;
    logic           cand_found;
    logic [W-1:0]   cand_idx;

    always_comb begin
        capture  = (EDGE == CAP_EDGE) ? (req_i & ~req_prev) : req_i;
        accept   = out_valid & out_ready;
        clear    = accept ? (N'(1) << out_idx) : '0;
        // The bit being accepted this cycle must not be re-offered as the next candidate.
        cand_vec = pending & mask_i & ~clear;
    end

    prio_pick #(
        .N          (N),
        .HIGH_FIRST (HIGH_FIRST)
    ) u_pick (
        .vec   (cand_vec),
        .found (cand_found),
        .idx   (cand_idx)
    );

    // Capture is OR-ed after the clear so a fresh event on the accepted bit survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            req_prev <= '0;
        end else begin
            pending  <= (pending & ~clear) | capture;
            req_prev <= req_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_found) begin
                        out_idx <= cand_idx;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (cand_found) begin
                            out_idx <= cand_idx;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == PRESENT);
    assign pending_o = pending;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// Scoreboard bench for prio_irq_encoder: three instances cover high-first edge,
// low-first edge and high-first level capture.
module tb_prio_irq_encoder;
    import prio_enc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_h, mask_h, req_l, mask_l, req_v, mask_v;
    logic       ready_h, ready_l, ready_v;
    logic       valid_h, valid_l, valid_v;
    logic [2:0] idx_h, idx_l, idx_v;
    logic [7:0] pend_h, pend_l, pend_v;

    int exp_q[$];
    int total = 0;
    int bad   = 0;

    prio_irq_encoder #(.N(8), .HIGH_FIRST(PRIO_HIGH_FIRST), .EDGE(CAP_EDGE)) dut_h (
        .clk(clk), .rst_n(rst_n), .req_i(req_h), .mask_i(mask_h),
        .out_valid(valid_h), .out_ready(ready_h), .out_idx(idx_h), .pending_o(pend_h)
    );

    prio_irq_encoder #(.N(8), .HIGH_FIRST(PRIO_LOW_FIRST), .EDGE(CAP_EDGE)) dut_l (
        .clk(clk), .rst_n(rst_n), .req_i(req_l), .mask_i(mask_l),
        .out_valid(valid_l), .out_ready(ready_l), .out_idx(idx_l), .pending_o(pend_l)
    );

    prio_irq_encoder #(.N(8), .HIGH_FIRST(PRIO_HIGH_FIRST), .EDGE(CAP_LEVEL)) dut_v (
        .clk(clk), .rst_n(rst_n), .req_i(req_v), .mask_i(mask_v),
        .out_valid(valid_v), .out_ready(ready_v), .out_idx(idx_v), .pending_o(pend_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        req_h = '0; mask_h = 8'hFF; ready_h = 1'b0;
        req_l = '0; mask_l = 8'hFF; ready_l = 1'b0;
        req_v = '0; mask_v = 8'hFF; ready_v = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_h); end
        total++; if (idx_h !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d exp=0", idx_h); end
        total++; if (pend_h !== 8'h00) begin bad++; $display("FAIL rst_pending got=%h exp=00", pend_h); end
        total++; if (valid_l !== 1'b0 || valid_v !== 1'b0) begin bad++; $display("FAIL rst_valid_other got=%b%b exp=00", valid_l, valid_v); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_edge_high();
        int got;
        mask_h = 8'hFF; ready_h = 1'b1; req_h = 8'h0E;
        exp_q = {3, 2, 1};
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                req_h = 8'h00;
                total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", valid_h); end
            end
            if (k == 2) begin
                total++; if (valid_h !== 1'b1) begin bad++; $display("FAIL t1_latency got=%b exp=1", valid_h); end
            end
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t1_unexpected got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t1_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t1_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL t1_idle got=%b exp=0", valid_h); end
        total++; if (pend_h !== 8'h00) begin bad++; $display("FAIL t1_pending got=%h exp=00", pend_h); end
    endtask

    task automatic test_stall();
        int got;
        ready_h = 1'b0; req_h = 8'h02;
        @(negedge clk); req_h = 8'h00;
        @(negedge clk);
        total++; if (valid_h !== 1'b1 || idx_h !== 3'd1) begin bad++; $display("FAIL t2_present got=%b/%0d exp=1/1", valid_h, idx_h); end
        req_h = 8'h80;
        @(negedge clk); req_h = 8'h00;
        for (int k = 0; k < 3; k++) begin
            total++; if (idx_h !== 3'd1 || valid_h !== 1'b1) begin bad++; $display("FAIL t2_hold got=%b/%0d exp=1/1", valid_h, idx_h); end
            total++; if (pend_h !== 8'h82) begin bad++; $display("FAIL t2_pending got=%h exp=82", pend_h); end
            @(negedge clk);
        end
        ready_h = 1'b1;
        exp_q = {1, 7};
        for (int k = 0; k < 6; k++) begin
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t2_unexpected got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t2_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t2_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL t2_idle got=%b exp=0", valid_h); end
    endtask

    task automatic test_mask();
        int got;
        mask_h = 8'h7F; ready_h = 1'b1; req_h = 8'h84;
        exp_q = {2};
        for (int k = 0; k < 6; k++) begin
            if (k == 1) req_h = 8'h00;
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t3_unexpected got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t3_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t3_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL t3_masked_idle got=%b exp=0", valid_h); end
        total++; if (pend_h !== 8'h80) begin bad++; $display("FAIL t3_masked_pending got=%h exp=80", pend_h); end
        mask_h = 8'hFF;
        exp_q = {7};
        for (int k = 0; k < 5; k++) begin
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t3_unexpected2 got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t3_unmask_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t3_unmask_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (pend_h !== 8'h00) begin bad++; $display("FAIL t3_drained got=%h exp=00", pend_h); end
    endtask

    task automatic test_low_first();
        int got;
        mask_l = 8'hFF; ready_l = 1'b1; req_l = 8'hC2;
        exp_q = {1, 6, 7};
        for (int k = 0; k < 8; k++) begin
            if (k == 1) req_l = 8'h00;
            if (valid_l && ready_l) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t4_unexpected got=%0d exp=none", idx_l); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_l !== 3'(got)) begin bad++; $display("FAIL t4_idx got=%0d exp=%0d", idx_l, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t4_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (valid_l !== 1'b0 || pend_l !== 8'h00) begin bad++; $display("FAIL t4_idle got=%b/%h exp=0/00", valid_l, pend_l); end
    endtask

    task automatic test_level();
        int got;
        mask_v = 8'hFF; ready_v = 1'b1; req_v = 8'h09;
        exp_q = {3, 0, 3, 0};
        for (int k = 0; k < 8; k++) begin
            if (valid_v && ready_v && exp_q.size() != 0) begin
                total++;
                got = exp_q.pop_front();
                if (idx_v !== 3'(got)) begin bad++; $display("FAIL lvl_idx got=%0d exp=%0d", idx_v, got); end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lvl_timeout got=%0d left exp=0", exp_q.size()); end
        req_v = 8'h00;
        repeat (6) @(negedge clk);
        total++; if (valid_v !== 1'b0 || pend_v !== 8'h00) begin bad++; $display("FAIL lvl_drain got=%b/%h exp=0/00", valid_v, pend_v); end
    endtask

    task automatic test_set_wins();
        int got;
        ready_h = 1'b0; req_h = 8'h20;
        @(negedge clk); req_h = 8'h00;
        @(negedge clk);
        total++; if (valid_h !== 1'b1 || idx_h !== 3'd5) begin bad++; $display("FAIL t5_present got=%b/%0d exp=1/5", valid_h, idx_h); end
        req_h = 8'h20; ready_h = 1'b1;
        exp_q = {5, 5};
        for (int k = 0; k < 8; k++) begin
            if (k == 1) begin
                req_h = 8'h00;
                total++; if (pend_h[5] !== 1'b1) begin bad++; $display("FAIL t5_repend got=%b exp=1", pend_h[5]); end
            end
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t5_unexpected got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t5_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t5_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (pend_h !== 8'h00 || valid_h !== 1'b0) begin bad++; $display("FAIL t5_idle got=%b/%h exp=0/00", valid_h, pend_h); end
    endtask

    task automatic test_mid_reset();
        int got;
        ready_h = 1'b0; req_h = 8'h0E;
        @(negedge clk); req_h = 8'h00;
        @(negedge clk);
        total++; if (valid_h !== 1'b1 || pend_h !== 8'h0E) begin bad++; $display("FAIL t6_pre got=%b/%h exp=1/0e", valid_h, pend_h); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (pend_h !== 8'h00) begin bad++; $display("FAIL t6_rst_pending got=%h exp=00", pend_h); end
        total++; if (valid_h !== 1'b0) begin bad++; $display("FAIL t6_rst_valid got=%b exp=0", valid_h); end
        total++; if (idx_h !== 3'd0) begin bad++; $display("FAIL t6_rst_idx got=%0d exp=0", idx_h); end
        req_h = 8'h01; ready_h = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q = {0};
        for (int k = 0; k < 8; k++) begin
            if (valid_h && ready_h) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL t6_unexpected got=%0d exp=none", idx_h); end
                else begin
                    got = exp_q.pop_front();
                    if (idx_h !== 3'(got)) begin bad++; $display("FAIL t6_idx got=%0d exp=%0d", idx_h, got); end
                end
            end
            @(negedge clk);
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL t6_timeout got=%0d left exp=0", exp_q.size()); end
        total++; if (valid_h !== 1'b0 || pend_h !== 8'h00) begin bad++; $display("FAIL t6_idle got=%b/%h exp=0/00", valid_h, pend_h); end
        req_h = 8'h00;
    endtask

    initial begin
        test_reset();
        test_edge_high();
        test_stall();
        test_mask();
        test_low_first();
        test_level();
        test_set_wins();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
